// File: rtl/mshr_entry_alloc_req_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : mshr_entry_alloc_req_if
// Brief   : Allocate / release / probe bundle for the MSHR entry allocator.
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
interface mshr_entry_alloc_req_if #(
    parameter int unsigned NUM_ENTRY = 4,
    parameter int unsigned TAG_WIDTH = 24
);
    localparam int unsigned IDX_W = $clog2(NUM_ENTRY);

    logic                 alloc_valid_i;
    logic [TAG_WIDTH-1:0] alloc_tag_i;
    logic                 alloc_ready_o;
    logic [IDX_W-1:0]     alloc_idx_o;
    logic                 release_valid_i;
    logic [IDX_W-1:0]     release_idx_i;
    logic [TAG_WIDTH-1:0] probe_tag_i;
    logic                 probe_hit_o;
    logic [IDX_W-1:0]     probe_idx_o;
    logic [NUM_ENTRY-1:0] valid_list_o;
    logic [IDX_W:0]       used_o;
    logic                 full_o;
    logic                 release_err_o;

    modport slave (
        input  alloc_valid_i, alloc_tag_i, release_valid_i, release_idx_i, probe_tag_i,
        output alloc_ready_o, alloc_idx_o, probe_hit_o, probe_idx_o,
               valid_list_o, used_o, full_o, release_err_o
    );

    modport master (
        output alloc_valid_i, alloc_tag_i, release_valid_i, release_idx_i, probe_tag_i,
        input  alloc_ready_o, alloc_idx_o, probe_hit_o, probe_idx_o,
               valid_list_o, used_o, full_o, release_err_o
    );
endinterface
`default_nettype wire

// File: rtl/mshr_entry_alloc_req.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : mshr_entry_alloc_req
// Brief   : MSHR entry allocator with tag probe; optional full-state
//           alloc/release bypass enabled by MSHR_ALLOC_RELEASE_BYPASS_EN.
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
module mshr_entry_alloc_req #(
    parameter int unsigned NUM_ENTRY = 4,
    parameter int unsigned TAG_WIDTH = 24
) (
    input  wire                     clk,
    input  wire                     rst,
    mshr_entry_alloc_req_if.slave   bus
);
    localparam int unsigned IDX_W = $clog2(NUM_ENTRY);

    logic [NUM_ENTRY-1:0] r_valid;
    logic [TAG_WIDTH-1:0] r_tag [NUM_ENTRY];
    logic [IDX_W:0]       r_used;
    logic                 r_release_err;

    logic                 w_full;
    logic                 w_rel_legal;
    logic                 w_alloc_ready;
    logic                 w_alloc_fire;
    logic [IDX_W-1:0]     w_free_idx;
    logic [IDX_W-1:0]     w_alloc_idx;
    logic                 w_probe_hit;
    logic [IDX_W-1:0]     w_probe_idx;
    logic [NUM_ENTRY-1:0] w_valid_nxt;
    logic [IDX_W:0]       w_used_nxt;

    assign w_full      = &r_valid;
    assign w_rel_legal = bus.release_valid_i && r_valid[bus.release_idx_i];

    // Lowest-index free entry; scanning downward lets the lowest one win.
    always_comb begin
        w_free_idx = '0;
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

`ifdef MSHR_ALLOC_RELEASE_BYPASS_EN
    // When full, a legal release hands its slot straight to the new request.
    assign w_alloc_ready = !w_full || w_rel_legal;
    assign w_alloc_idx   = w_full ? bus.release_idx_i : w_free_idx;
`else
    assign w_alloc_ready = !w_full;
    assign w_alloc_idx   = w_free_idx;
`endif

    assign w_alloc_fire = bus.alloc_valid_i && w_alloc_ready;

    // Probe sees registered state only.
    always_comb begin
        w_probe_hit = 1'b0;
        w_probe_idx = '0;
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == bus.probe_tag_i)) begin
                w_probe_hit = 1'b1;
                w_probe_idx = IDX_W'(i);
            end
        end
    end

    // Allocation applied after release so a bypassed slot ends up valid.
    always_comb begin
        w_valid_nxt = r_valid;
        if (w_rel_legal) begin
            w_valid_nxt[bus.release_idx_i] = 1'b0;
        end
        if (w_alloc_fire) begin
            w_valid_nxt[w_alloc_idx] = 1'b1;
        end
    end

    always_comb begin
        w_used_nxt = r_used;
        case ({w_alloc_fire, w_rel_legal})
            2'b10:   w_used_nxt = r_used + {{IDX_W{1'b0}}, 1'b1};
            2'b01:   w_used_nxt = r_used - {{IDX_W{1'b0}}, 1'b1};
            default: w_used_nxt = r_used;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= '0;
            r_used        <= '0;
            r_release_err <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
            r_used  <= w_used_nxt;
            if (bus.release_valid_i && !r_valid[bus.release_idx_i]) begin
                r_release_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_alloc_fire) begin
            r_tag[w_alloc_idx] <= bus.alloc_tag_i;
        end
    end

    assign bus.alloc_ready_o = w_alloc_ready;
    assign bus.alloc_idx_o   = w_alloc_idx;
    assign bus.probe_hit_o   = w_probe_hit;
    assign bus.probe_idx_o   = w_probe_idx;
    assign bus.valid_list_o  = r_valid;
    assign bus.used_o        = r_used;
    assign bus.full_o        = w_full;
    assign bus.release_err_o = r_release_err;

endmodule
`default_nettype wire

// File: tb/tb_mshr_entry_alloc_req.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_mshr_entry_alloc_req
// Brief   : Directed self-checking bench for mshr_entry_alloc_req.
// Revision: 1.0  initial release
// ----------------------------------------------------------------------------
module tb_mshr_entry_alloc_req;
    localparam int unsigned NUM_ENTRY = 4;
    localparam int unsigned TAG_WIDTH = 24;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    mshr_entry_alloc_req_if #(.NUM_ENTRY(NUM_ENTRY), .TAG_WIDTH(TAG_WIDTH)) bus ();

    mshr_entry_alloc_req #(.NUM_ENTRY(NUM_ENTRY), .TAG_WIDTH(TAG_WIDTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_valid_i   = 1'b0;
        bus.alloc_tag_i     = '0;
        bus.release_valid_i = 1'b0;
        bus.release_idx_i   = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic alloc(input logic [TAG_WIDTH-1:0] tag, input logic [31:0] exp_idx, input string nm);
        bus.alloc_valid_i = 1'b1;
        bus.alloc_tag_i   = tag;
        #1;
        chk(nm, 32'(bus.alloc_idx_o), exp_idx);
        tick();
        idle();
    endtask

    task automatic release_entry(input logic [1:0] idx);
        bus.release_valid_i = 1'b1;
        bus.release_idx_i   = idx;
        tick();
        idle();
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        bus.probe_tag_i = '0;
        do_reset();

        chk("rst_ready", 32'(bus.alloc_ready_o), 32'd1);
        chk("rst_idx",   32'(bus.alloc_idx_o),   32'd0);
        chk("rst_full",  32'(bus.full_o),        32'd0);
        chk("rst_hit",   32'(bus.probe_hit_o),   32'd0);
        chk("rst_pidx",  32'(bus.probe_idx_o),   32'd0);
        chk("rst_valid", 32'(bus.valid_list_o),  32'd0);
        chk("rst_used",  32'(bus.used_o),        32'd0);
        chk("rst_err",   32'(bus.release_err_o), 32'd0);

        // Fill all four entries.
        for (int i = 0; i < 4; i++) begin
            alloc(TAG_WIDTH'(32'h10 + i), 32'(i), $sformatf("fill_idx%0d", i));
        end
        #1;
        chk("fill_used",  32'(bus.used_o),        32'd4);
        chk("fill_full",  32'(bus.full_o),        32'd1);
        chk("fill_ready", 32'(bus.alloc_ready_o), 32'd0);
        chk("fill_valid", 32'(bus.valid_list_o),  32'hF);
        bus.probe_tag_i = 24'h12;
        #1;
        chk("probe12_hit", 32'(bus.probe_hit_o), 32'd1);
        chk("probe12_idx", 32'(bus.probe_idx_o), 32'd2);

        // Request while full is dropped.
        bus.alloc_valid_i = 1'b1;
        bus.alloc_tag_i   = 24'h99;
        tick();
        idle();
        bus.probe_tag_i = 24'h99;
        #1;
        chk("full_drop_hit",  32'(bus.probe_hit_o), 32'd0);
        chk("full_drop_used", 32'(bus.used_o),      32'd4);

        release_entry(2'd1);
        chk("rel1_valid", 32'(bus.valid_list_o), 32'hD);
        chk("rel1_used",  32'(bus.used_o),       32'd3);
        chk("rel1_full",  32'(bus.full_o),       32'd0);
        alloc(24'h20, 32'd1, "realloc_idx");
        #1;
        chk("realloc_valid", 32'(bus.valid_list_o), 32'hF);

        // Simultaneous alloc and release keeps the count.
        do_reset();
        alloc(24'h01, 32'd0, "sim_a0");
        alloc(24'h02, 32'd1, "sim_a1");
        bus.alloc_valid_i   = 1'b1;
        bus.alloc_tag_i     = 24'h03;
        bus.release_valid_i = 1'b1;
        bus.release_idx_i   = 2'd0;
        #1;
        chk("sim_idx", 32'(bus.alloc_idx_o), 32'd2);
        tick();
        idle();
        #1;
        chk("sim_valid", 32'(bus.valid_list_o), 32'h6);
        chk("sim_used",  32'(bus.used_o),       32'd2);

        // Probe returns the lowest match.
        do_reset();
        alloc(24'hAB, 32'd0, "pr_a0");
        alloc(24'hCD, 32'd1, "pr_a1");
        alloc(24'hAB, 32'd2, "pr_a2");
        bus.probe_tag_i = 24'hAB;
        #1;
        chk("pr_hit",  32'(bus.probe_hit_o), 32'd1);
        chk("pr_idx0", 32'(bus.probe_idx_o), 32'd0);
        release_entry(2'd0);
        chk("pr_idx2", 32'(bus.probe_idx_o), 32'd2);
        bus.probe_tag_i = 24'hEE;
        #1;
        chk("pr_miss_hit", 32'(bus.probe_hit_o), 32'd0);
        chk("pr_miss_idx", 32'(bus.probe_idx_o), 32'd0);

        // Allocation in flight is invisible to the probe until the edge.
        bus.probe_tag_i   = 24'h77;
        bus.alloc_valid_i = 1'b1;
        bus.alloc_tag_i   = 24'h77;
        #1;
        chk("pr_same_cyc", 32'(bus.probe_hit_o), 32'd0);
        tick();
        idle();
        #1;
        chk("pr_next_hit", 32'(bus.probe_hit_o), 32'd1);
        chk("pr_next_idx", 32'(bus.probe_idx_o), 32'd0);

        // Illegal release: sticky error, no state change.
        release_entry(2'd3);
        chk("err_flag",  32'(bus.release_err_o), 32'd1);
        chk("err_used",  32'(bus.used_o),        32'd3);
        chk("err_valid", 32'(bus.valid_list_o),  32'h7);
        tick();
        tick();
        chk("err_sticky", 32'(bus.release_err_o), 32'd1);
        do_reset();
        chk("err_clear", 32'(bus.release_err_o), 32'd0);

        // Full plus legal release with a new request.
        for (int i = 0; i < 4; i++) begin
            alloc(TAG_WIDTH'(32'h30 + i), 32'(i), $sformatf("byp_fill%0d", i));
        end
        bus.alloc_valid_i   = 1'b1;
        bus.alloc_tag_i     = 24'h55;
        bus.release_valid_i = 1'b1;
        bus.release_idx_i   = 2'd2;
        bus.probe_tag_i     = 24'h55;
        #1;
`ifdef MSHR_ALLOC_RELEASE_BYPASS_EN
        chk("byp_ready", 32'(bus.alloc_ready_o), 32'd1);
        chk("byp_idx",   32'(bus.alloc_idx_o),   32'd2);
        tick();
        idle();
        #1;
        chk("byp_used",  32'(bus.used_o),       32'd4);
        chk("byp_valid", 32'(bus.valid_list_o), 32'hF);
        chk("byp_hit",   32'(bus.probe_hit_o),  32'd1);
        chk("byp_pidx",  32'(bus.probe_idx_o),  32'd2);
`else
        chk("nobyp_ready", 32'(bus.alloc_ready_o), 32'd0);
        tick();
        idle();
        #1;
        chk("nobyp_used",  32'(bus.used_o),       32'd3);
        chk("nobyp_valid", 32'(bus.valid_list_o), 32'hB);
        chk("nobyp_hit",   32'(bus.probe_hit_o),  32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/mshr_entry_alloc_req.md
MSHR_ENTRY_ALLOC_REQ -- requirements
Module: mshr_entry_alloc_req

Interface
REQ-001 SHALL have parameter NUM_ENTRY, default 4: number of MSHR entries, power of two, at least 2.
REQ-002 SHALL have parameter TAG_WIDTH, default 24: width of the block-address tag stored per entry.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port alloc_valid_i, input, 1: miss request asks for a new entry.
REQ-006 SHALL have port alloc_tag_i, input, TAG_WIDTH: block tag to store in the allocated entry.
REQ-007 SHALL have port alloc_ready_o, output, 1: an entry can be granted this cycle.
REQ-008 SHALL have port alloc_idx_o, output, $clog2(NUM_ENTRY): index granted when alloc_valid_i and alloc_ready_o are both high.
REQ-009 SHALL have port release_valid_i, input, 1: a response frees an entry.
REQ-010 SHALL have port release_idx_i, input, $clog2(NUM_ENTRY): entry to free.
REQ-011 SHALL have port probe_tag_i, input, TAG_WIDTH: tag for secondary-miss lookup.
REQ-012 SHALL have port probe_hit_o, output, 1: some valid entry holds probe_tag_i.
REQ-013 SHALL have port probe_idx_o, output, $clog2(NUM_ENTRY): lowest matching index; 0 when there is no hit.
REQ-014 SHALL have port valid_list_o, output, NUM_ENTRY: registered per-entry valid bits, bit i for entry i.
REQ-015 SHALL have port used_o, output, $clog2(NUM_ENTRY)+1: registered count of valid entries.
REQ-016 SHALL have port full_o, output, 1: used_o equals NUM_ENTRY.
REQ-017 SHALL have port release_err_o, output, 1: sticky flag for a release that targets an invalid entry.

Function
REQ-018 SHALL drive alloc_idx_o with the lowest-index entry whose valid bit is 0, combinationally from registered state.
REQ-019 SHALL, on a handshake (alloc_valid_i and alloc_ready_o), set valid[alloc_idx_o] and write alloc_tag_i into that entry at the next edge; latency is 1 cycle.
REQ-020 SHALL, on release_valid_i with valid[release_idx_i] set, clear that valid bit at the next edge; the stored tag is not cleared.
REQ-021 SHALL, on release_valid_i with valid[release_idx_i] clear, leave all state unchanged except setting release_err_o to 1.
REQ-022 SHALL keep release_err_o at 1 until reset.
REQ-023 SHALL update used_o by +1 on a handshake only, by -1 on a legal release only, and hold it when both happen in the same cycle.
REQ-024 SHALL keep used_o equal to the popcount of valid_list_o at all times; it never wraps.
REQ-025 SHALL compute probe_hit_o and probe_idx_o combinationally from registered valid bits and tags only; a same-cycle allocation is not visible to the probe.
REQ-026 SHALL drive full_o high exactly when all NUM_ENTRY valid bits are set.
REQ-027 SHALL ignore alloc_valid_i while alloc_ready_o is low; nothing is stored.
REQ-028 SHALL NOT require alloc_ready_o to depend on alloc_valid_i.

Reset
REQ-029 SHALL, while rst is high at a rising edge, clear valid_list_o, used_o and release_err_o to 0 and ignore alloc and release inputs.
REQ-030 SHALL leave tag storage unreset; tags are qualified by valid bits.
REQ-031 SHALL, after reset, present alloc_ready_o=1, alloc_idx_o=0, full_o=0, probe_hit_o=0 and probe_idx_o=0.

Configuration
REQ-032 SHALL support macro MSHR_ALLOC_RELEASE_BYPASS_EN.
REQ-033 SHALL, when MSHR_ALLOC_RELEASE_BYPASS_EN is defined, drive alloc_ready_o = !full_o OR (release_valid_i AND valid[release_idx_i]). When full, alloc_idx_o = release_idx_i; on a handshake, that entry is set valid again with the new tag and used_o is unchanged.
REQ-034 SHALL, when MSHR_ALLOC_RELEASE_BYPASS_EN is undefined, drive alloc_ready_o = !full_o with no dependence on release inputs.

Verification
REQ-035 SHALL cover: reset, then 4 allocs with tags 0x10..0x13 -> idx 0,1,2,3; used_o=4; full_o=1; alloc_ready_o=0 (bypass off).
REQ-036 SHALL cover: entries 0-3 valid, release idx 1 -> next cycle valid_list_o=4'b1101 and used_o=3; next alloc gets idx 1.
REQ-037 SHALL cover: used_o=2 (entries 0,1), same-cycle alloc and release idx 0 -> valid_list_o=4'b0110 and used_o=2.
REQ-038 SHALL cover: entries 0,2 hold tag 0xAB, probe 0xAB -> probe_hit_o=1 and probe_idx_o=0; after release of 0, probe_idx_o=2.
REQ-039 SHALL cover: release idx 3 while valid[3]=0 -> release_err_o=1 and used_o unchanged; it stays 1 until rst.
REQ-040 SHALL cover, with bypass on: full, alloc tag 0x55 plus release idx 2 -> alloc_ready_o=1, alloc_idx_o=2, used_o stays 4, probe 0x55 hits at idx 2.
